// File: rtl/byte_mem_responder_if.sv
// Byte memory bus: request fields from the initiator, read data and hold from the target.
// errAddr_o exists only when BYTE_MEM_RESPONDER_ERR_EN is defined.
interface byte_mem_responder_if #(
  parameter int unsigned DATA_BYTE = 4,
  parameter int unsigned ADDR_SIZE = 32
);
  logic                   enable_i;
  logic                   isWrite_i;
  logic [DATA_BYTE-1:0]   writeMask_i;
  logic [ADDR_SIZE-1:0]   addr_i;
  logic [DATA_BYTE*8-1:0] writeData_i;
  logic [DATA_BYTE*8-1:0] readData_o;
  logic                   hold_o;
`ifdef BYTE_MEM_RESPONDER_ERR_EN
  logic                   errAddr_o;
`endif

  modport master (
    output enable_i, isWrite_i, writeMask_i, addr_i, writeData_i,
`ifdef BYTE_MEM_RESPONDER_ERR_EN
    input  errAddr_o,
`endif
    input  readData_o, hold_o
  );

  modport slave (
    input  enable_i, isWrite_i, writeMask_i, addr_i, writeData_i,
`ifdef BYTE_MEM_RESPONDER_ERR_EN
    output errAddr_o,
`endif
    output readData_o, hold_o
  );
endinterface

// File: rtl/byte_mem_responder.sv
// Word-wide RAM behind the byte memory bus with programmable wait states and byte-lane masking.
// Optional BYTE_MEM_RESPONDER_ERR_EN: out-of-range accesses are dropped and flagged on errAddr_o.
module byte_mem_responder #(
  parameter int unsigned DATA_BYTE   = 4,
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  byte_mem_responder_if.slave  bus
);

  localparam int unsigned OFF_W = $clog2(DATA_BYTE);
  localparam int unsigned DEP_W = $clog2(DEPTH);
  localparam int unsigned DW    = DATA_BYTE * 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

  logic [CNT_W-1:0]     r_cnt;
  logic [DW-1:0]        r_rdata;
  logic [DW-1:0]        r_mem [DEPTH];

  logic                 w_hold;
  logic                 w_accept;
  logic                 w_wr_en;
  logic                 w_oob;
  logic [DEP_W-1:0]     w_idx;
  logic [ADDR_SIZE-1:0] w_unused_addr;

  // Byte offset is ignored; in the wrapping build the upper index bits are dropped too.
  assign w_idx         = bus.addr_i[OFF_W +: DEP_W];
  assign w_unused_addr = bus.addr_i;

`ifdef BYTE_MEM_RESPONDER_ERR_EN
  assign w_oob = |bus.addr_i[ADDR_SIZE-1:OFF_W+DEP_W];
`else
  assign w_oob = 1'b0;
`endif

  assign w_hold   = bus.enable_i && (r_cnt != WAIT_LAST);
  assign w_accept = bus.enable_i && !w_hold;
  assign w_wr_en  = w_accept && bus.isWrite_i && !w_oob && !rst_i;

  assign bus.hold_o     = w_hold;
  assign bus.readData_o = r_rdata;

  // Wait-state counter and registered read data; any non-holding cycle restarts the wait.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_hold) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_accept && !bus.isWrite_i) begin
        r_rdata <= w_oob ? '0 : r_mem[w_idx];
      end
    end
  end

  // RAM is not reset; writes are lane-masked.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int i = 0; i < int'(DATA_BYTE); i++) begin
        if (bus.writeMask_i[i]) begin
          r_mem[w_idx][i*8 +: 8] <= bus.writeData_i[i*8 +: 8];
        end
      end
    end
  end

`ifdef BYTE_MEM_RESPONDER_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && w_oob;
    end
  end

  assign bus.errAddr_o = r_err;
`endif

endmodule
